// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// One transaction in flight; data side wins ties until its streak limit.
module mem_port_arbiter #(
    parameter int unsigned MAX_LS_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_rdata,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [63:0] ls_req_addr,
    input  logic [63:0] ls_req_wdata,
    input  logic        ls_req_wen,
    output logic        ls_resp_valid,
    output logic [63:0] ls_resp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wen,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    state_t     state;
    logic [3:0] streak;
    logic       owner_ls;
    logic       word_hi;
    logic       if_win;
    logic       ls_win;

    always_comb begin
        if_win = 1'b0;
        ls_win = 1'b0;
        if (state == IDLE) begin
            if_win = if_req_valid && (!ls_req_valid || streak == STREAK_MAX);
            ls_win = ls_req_valid && !if_win;
        end
    end

    assign if_req_ready = if_win;
    assign ls_req_ready = ls_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            streak        <= '0;
            owner_ls      <= 1'b0;
            word_hi       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wen       <= 1'b0;
            if_resp_valid <= 1'b0;
            if_resp_rdata <= '0;
            ls_resp_valid <= 1'b0;
            ls_resp_rdata <= '0;
        end else begin
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ls_win) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        owner_ls      <= 1'b1;
                        word_hi       <= 1'b0;
                        mem_addr      <= {ls_req_addr[63:3], 3'b000};
                        mem_wdata     <= ls_req_wdata;
                        mem_wen       <= ls_req_wen;
                        // Streak only counts grants that made a fetch wait.
                        if (!if_req_valid)
                            streak <= '0;
                        else if (streak < STREAK_MAX)
                            streak <= streak + 4'd1;
                    end else if (if_win) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        owner_ls      <= 1'b0;
                        word_hi       <= if_req_addr[2];
                        mem_addr      <= {if_req_addr[63:3], 3'b000};
                        mem_wdata     <= '0;
                        mem_wen       <= 1'b0;
                        streak        <= '0;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                        if (owner_ls) begin
                            ls_resp_valid <= 1'b1;
                            ls_resp_rdata <= mem_wen ? 64'd0 : mem_rdata;
                        end else begin
                            if_resp_valid <= 1'b1;
                            if_resp_rdata <= word_hi ? mem_rdata[63:32]
                                                     : mem_rdata[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing scenarios plus a randomized
// run against a transaction-level reference model and memory responder.
module tb_mem_port_arbiter;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_resp_valid;
    logic [31:0] if_resp_rdata;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [63:0] ls_req_addr;
    logic [63:0] ls_req_wdata;
    logic        ls_req_wen;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wen;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_LS_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr), .if_resp_valid(if_resp_valid),
        .if_resp_rdata(if_resp_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_req_wen(ls_req_wen), .ls_resp_valid(ls_resp_valid),
        .ls_resp_rdata(ls_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cfg_lat      = 1;
    bit cfg_lat_rand = 0;
    int cfg_stall    = 0;
    int stray_req    = 0;
    int stray_seen   = 0;

    logic [63:0] bank    [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];

    function automatic logic [63:0] init_word(input logic [63:0] a);
        if (a == 64'h1000) return 64'hDEADBEEF_12345678;
        return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
    endfunction

    function automatic logic [63:0] bank_rd(input logic [63:0] a);
        if (bank.exists(a)) return bank[a];
        return init_word(a);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // Memory responder: stall/latency set by cfg_*, garbage rdata otherwise.
    bit          hs_flag = 0;
    logic [63:0] cap_addr, cap_wdata, resp_word;
    logic        cap_wen;
    int          resp_cnt  = 0;
    int          stall_cnt = 0;

    always begin
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        mem_rdata = {$urandom, $urandom};
        if (hs_flag) begin
            hs_flag = 0;
            if (cap_wen) begin
                bank[cap_addr] = cap_wdata;
                resp_word = {$urandom, $urandom};
            end else begin
                resp_word = bank_rd(cap_addr);
            end
            resp_cnt = cfg_lat_rand ? int'($urandom_range(1, 4)) : cfg_lat;
        end
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_rdata = resp_word;
            end
        end else if (stray_seen != stray_req) begin
            stray_seen = stray_req;
            mem_resp_valid = 1'b1;
        end
        if (mem_req_valid) begin
            if (stall_cnt > 0) begin
                mem_req_ready = 1'b0;
                stall_cnt--;
            end else begin
                mem_req_ready = 1'b1;
            end
        end else begin
            mem_req_ready = 1'b0;
            stall_cnt = (cfg_stall < 0) ? int'($urandom_range(0, 3)) : cfg_stall;
        end
        if (mem_req_valid && mem_req_ready) begin
            hs_flag   = 1;
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
            cap_wen   = mem_wen;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid,
             mem_req_valid, mem_wen} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {if_req_ready, ls_req_ready, if_resp_valid,
                      ls_resp_valid, mem_req_valid, mem_wen});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, ls_resp_rdata, if_resp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h wdata %h ls %h if %h required 0",
                     mem_addr, mem_wdata, ls_resp_rdata, if_resp_rdata);
        end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_single_fetch(input logic [63:0] a,
                                     input logic [31:0] exp);
        cfg_lat = 1;
        cfg_stall = 0;
        cfg_lat_rand = 0;
        tick;
        if_req_valid = 1'b1;
        if_req_addr = a;
        @(negedge clk);
        n_checks++;
        if ({if_req_ready, ls_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_accept: got %b required 10",
                     {if_req_ready, ls_req_ready});
        end
        tick;
        if_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_req_valid, mem_wen, mem_addr, mem_wdata} !==
            {1'b1, 1'b0, a & ~64'h7, 64'd0}) begin
            n_fail++;
            $display("FAIL fetch_memreq: v %b wen %b addr %h wdata %h required 1 0 %h 0",
                     mem_req_valid, mem_wen, mem_addr, mem_wdata, a & ~64'h7);
        end
        tick;
        @(negedge clk);
        n_checks++;
        if (if_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_early_resp: got %b required 0", if_resp_valid);
        end
        tick;
        @(negedge clk);
        n_checks++;
        if ({if_resp_valid, ls_resp_valid, if_resp_rdata} !== {2'b10, exp}) begin
            n_fail++;
            $display("FAIL fetch_resp: v %b%b data %h required 10 %h",
                     if_resp_valid, ls_resp_valid, if_resp_rdata, exp);
        end
        tick;
        @(negedge clk);
        n_checks++;
        if ({if_resp_valid, if_resp_rdata} !== {1'b0, exp}) begin
            n_fail++;
            $display("FAIL fetch_hold: v %b data %h required 0 %h",
                     if_resp_valid, if_resp_rdata, exp);
        end
    endtask

    task automatic test_simultaneous;
        logic [63:0] w;
        tick;
        if_req_valid = 1'b1;
        if_req_addr = 64'h2000;
        ls_req_valid = 1'b1;
        ls_req_addr = 64'h3008;
        ls_req_wen = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if_req_ready, ls_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL simul_grant: got %b required 01",
                     {if_req_ready, ls_req_ready});
        end
        tick;
        ls_req_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (if_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_busy c%0d: got %b required 0", c, if_req_ready);
            end
            tick;
        end
        @(negedge clk);
        w = init_word(64'h3008);
        n_checks++;
        if ({ls_resp_valid, if_resp_valid, if_req_ready, ls_resp_rdata} !==
            {3'b101, w}) begin
            n_fail++;
            $display("FAIL simul_c3: ls_v %b if_v %b if_rdy %b data %h required 1 0 1 %h",
                     ls_resp_valid, if_resp_valid, if_req_ready, ls_resp_rdata, w);
        end
        tick;
        if_req_valid = 1'b0;
        tick;
        tick;
        @(negedge clk);
        w = init_word(64'h2000);
        n_checks++;
        if ({if_resp_valid, if_resp_rdata} !== {1'b1, w[31:0]}) begin
            n_fail++;
            $display("FAIL simul_if_resp: v %b data %h required 1 %h",
                     if_resp_valid, if_resp_rdata, w[31:0]);
        end
        tick;
    endtask

    task automatic test_starvation;
        int got = 0;
        bit order [6];
        bit exp_if;
        tick;
        if_req_valid = 1'b1;
        if_req_addr = 64'h2100;
        ls_req_valid = 1'b1;
        ls_req_addr = 64'h3100;
        ls_req_wen = 1'b0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if ((if_req_ready && ls_req_ready) !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_both_ready: got %b%b required not 11",
                         if_req_ready, ls_req_ready);
            end
            if (if_req_ready || ls_req_ready) begin
                order[got] = if_req_ready;
                got++;
            end
            tick;
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        n_checks++;
        if (got !== 6) begin
            n_fail++;
            $display("FAIL starve_count: got %0d grants required 6", got);
        end
        for (int i = 0; i < got; i++) begin
            exp_if = (i % (MAX + 1)) == MAX;
            n_checks++;
            if (order[i] !== exp_if) begin
                n_fail++;
                $display("FAIL starve_order[%0d]: got if=%b required if=%b",
                         i, order[i], exp_if);
            end
        end
        repeat (8) tick;
    endtask

    task automatic test_store_backpressure;
        int pulses = 0;
        cfg_stall = 5;
        tick;
        ls_req_valid = 1'b1;
        ls_req_wen = 1'b1;
        ls_req_addr = 64'h80;
        ls_req_wdata = 64'hA5A5;
        @(negedge clk);
        n_checks++;
        if (ls_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL store_accept: got %b required 1", ls_req_ready);
        end
        tick;
        ls_req_valid = 1'b0;
        ls_req_wen = 1'b0;
        ls_req_wdata = '0;
        ls_req_addr = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 6) begin
                n_checks++;
                if ({mem_req_valid, mem_wen, mem_addr, mem_wdata} !==
                    {2'b11, 64'h80, 64'hA5A5}) begin
                    n_fail++;
                    $display("FAIL store_hold c%0d: v %b wen %b addr %h wdata %h required 1 1 80 a5a5",
                             c, mem_req_valid, mem_wen, mem_addr, mem_wdata);
                end
            end
            if (ls_resp_valid) begin
                pulses++;
                n_checks++;
                if (ls_resp_rdata !== 64'd0) begin
                    n_fail++;
                    $display("FAIL store_rdata: got %h required 0", ls_resp_rdata);
                end
            end
            tick;
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL store_pulses: got %0d required 1", pulses);
        end
        cfg_stall = 0;
    endtask

    task automatic test_reset_in_resp;
        int pulses = 0;
        cfg_lat = 3;
        cfg_stall = 0;
        tick;
        if_req_valid = 1'b1;
        if_req_addr = 64'h1000;
        @(negedge clk);
        n_checks++;
        if (if_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstresp_accept: got %b required 1", if_req_ready);
        end
        tick;
        if_req_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if_resp_valid || ls_resp_valid) pulses++;
            n_checks++;
            if ({mem_req_valid, if_req_ready, ls_req_ready, mem_wen,
                 mem_addr, if_resp_rdata} !== '0) begin
                n_fail++;
                $display("FAIL rstresp_outputs c%0d: v %b addr %h wen %b if_data %h required 0",
                         c, mem_req_valid, mem_addr, mem_wen, if_resp_rdata);
            end
            tick;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL rstresp_pulses: got %0d required 0", pulses);
        end
        test_single_fetch(64'h1004, 32'hDEADBEEF);
    endtask

    task automatic test_stray;
        tick;
        stray_req++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({if_resp_valid, ls_resp_valid, mem_req_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL stray c%0d: if_v %b ls_v %b mem_v %b required 000",
                         c, if_resp_valid, ls_resp_valid, mem_req_valid);
            end
            tick;
        end
        test_single_fetch(64'h1000, 32'h12345678);
    endtask

    task automatic test_random;
        bit busy = 0, hs_done = 0, pulse_due = 0, own_ls = 0;
        bit g_if = 0, g_ls = 0, exp_if, exp_ls;
        int streak = 0;
        logic [63:0] e_addr = '0, e_wdata = '0, e_ls_data = '0, w;
        logic        e_wen = 1'b0;
        logic [31:0] e_if_data = '0;
        cfg_lat_rand = 1;
        cfg_stall = -1;
        for (int c = 0; c < 900; c++) begin
            tick;
            if (g_if || !if_req_valid) begin
                if_req_valid = $urandom_range(0, 99) < 55;
                if_req_addr = 64'h2000 + 64'($urandom_range(0, 255));
            end else if ($urandom_range(0, 99) < 8) begin
                if_req_valid = 1'b0;
            end
            if (g_ls || !ls_req_valid) begin
                ls_req_valid = $urandom_range(0, 99) < 60;
                ls_req_addr = 64'h3000 + 64'($urandom_range(0, 127));
                ls_req_wen = 1'($urandom_range(0, 1));
                ls_req_wdata = {$urandom, $urandom};
            end else if ($urandom_range(0, 99) < 8) begin
                ls_req_valid = 1'b0;
            end
            if (c >= 870) begin
                if_req_valid = 1'b0;
                ls_req_valid = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if ({if_resp_valid, ls_resp_valid} !==
                {pulse_due && !own_ls, pulse_due && own_ls}) begin
                n_fail++;
                $display("FAIL rand_pulse cyc %0d: got %b%b required %b%b", c,
                         if_resp_valid, ls_resp_valid,
                         pulse_due && !own_ls, pulse_due && own_ls);
            end
            if (pulse_due) begin
                n_checks++;
                if (own_ls && ls_resp_rdata !== e_ls_data) begin
                    n_fail++;
                    $display("FAIL rand_ls_data cyc %0d: got %h required %h",
                             c, ls_resp_rdata, e_ls_data);
                end else if (!own_ls && if_resp_rdata !== e_if_data) begin
                    n_fail++;
                    $display("FAIL rand_if_data cyc %0d: got %h required %h",
                             c, if_resp_rdata, e_if_data);
                end
                busy = 0;
                pulse_due = 0;
            end
            n_checks++;
            if (mem_req_valid !== (busy && !hs_done)) begin
                n_fail++;
                $display("FAIL rand_memvalid cyc %0d: got %b required %b",
                         c, mem_req_valid, busy && !hs_done);
            end else if (mem_req_valid) begin
                n_checks++;
                if ({mem_addr, mem_wdata, mem_wen} !== {e_addr, e_wdata, e_wen}) begin
                    n_fail++;
                    $display("FAIL rand_memreq cyc %0d: %h %h %b required %h %h %b",
                             c, mem_addr, mem_wdata, mem_wen, e_addr, e_wdata, e_wen);
                end
            end
            if (busy && hs_done && mem_resp_valid) pulse_due = 1;
            if (busy && mem_req_valid && mem_req_ready) hs_done = 1;
            exp_if = !busy && if_req_valid && (!ls_req_valid || streak == MAX);
            exp_ls = !busy && ls_req_valid && !exp_if;
            n_checks++;
            if ({if_req_ready, ls_req_ready} !== {exp_if, exp_ls}) begin
                n_fail++;
                $display("FAIL rand_grant cyc %0d: got %b%b required %b%b",
                         c, if_req_ready, ls_req_ready, exp_if, exp_ls);
            end
            if (exp_if) begin
                busy = 1; hs_done = 0; own_ls = 0;
                e_addr = if_req_addr & ~64'h7;
                e_wdata = '0;
                e_wen = 1'b0;
                w = ref_rd(e_addr);
                e_if_data = if_req_addr[2] ? w[63:32] : w[31:0];
                streak = 0;
            end else if (exp_ls) begin
                busy = 1; hs_done = 0; own_ls = 1;
                e_addr = ls_req_addr & ~64'h7;
                e_wdata = ls_req_wdata;
                e_wen = ls_req_wen;
                if (ls_req_wen) begin
                    ref_mem[e_addr] = ls_req_wdata;
                    e_ls_data = '0;
                end else begin
                    e_ls_data = ref_rd(e_addr);
                end
                streak = if_req_valid ? ((streak < MAX) ? streak + 1 : MAX) : 0;
            end
            g_if = exp_if;
            g_ls = exp_ls;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL rand_drain: transaction still outstanding, required none");
        end
        cfg_lat_rand = 0;
        cfg_stall = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b0;
        if_req_addr = '0;
        ls_req_valid = 1'b0;
        ls_req_addr = '0;
        ls_req_wdata = '0;
        ls_req_wen = 1'b0;
        test_reset;
        test_single_fetch(64'h1004, 32'hDEADBEEF);
        test_single_fetch(64'h1000, 32'h12345678);
        test_simultaneous;
        test_starvation;
        test_store_backpressure;
        test_reset_in_resp;
        test_stray;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified 64-bit memory port between the fetch stage (instruction reads) and the load/store path (data reads and writes).
- Each requester uses a valid/ready request channel and a single-cycle response pulse.
- The memory side uses a valid/ready request channel and a response-valid strobe.
- Exactly one transaction is outstanding at a time. Data accesses have priority, and a streak limit prevents fetch starvation.
- Sits between the core's fetch/LSU and the memory model, replacing the separate imem/dmem connections.

Parameters:
MAX_LS_STREAK, 4, maximum consecutive load/store grants while a fetch request is pending; range 1..15.

Ports:
clk  in  1  core clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  64  fetch byte address; bits [1:0] ignored
if_resp_valid  out  1  one-cycle fetch response pulse
if_resp_rdata  out  32  fetched instruction
ls_req_valid  in  1  load/store request valid
ls_req_ready  out  1  load/store request accepted this cycle
ls_req_addr  in  64  data byte address; bits [2:0] ignored
ls_req_wdata  in  64  store data
ls_req_wen  in  1  1 = store, 0 = load
ls_resp_valid  out  1  one-cycle load/store response pulse
ls_resp_rdata  out  64  load data; 0 for stores
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  64  memory address, doubleword aligned (bits [2:0] = 0)
mem_wdata  out  64  memory write data
mem_wen  out  1  memory write enable
mem_resp_valid  in  1  memory response/ack (loads and stores)
mem_rdata  in  64  memory read data

Behaviour:
- FSM states: IDLE, REQ, RESP. Reset puts the FSM in IDLE.
- Reset values: every output 0; internal latches 0; streak counter 0.
- Reset mid-transaction abandons the transaction: no resp_valid is generated and the FSM goes to IDLE next cycle.
- IDLE, no request valid: stay in IDLE.
- IDLE, at least one request valid:
  - Pick a winner and assert that requester's *_req_ready combinationally in the same cycle. *_req_ready is never asserted outside IDLE and never to both requesters.
  - Register the winner's address (low 3 bits cleared), wdata, wen and owner.
  - Next state: REQ.
- Arbitration:
  - If only one request is valid, that requester wins.
  - If both are valid, ls wins unless streak == MAX_LS_STREAK, in which case if wins.
- Streak counter:
  - Increments on an ls grant made while if_req_valid is 1; saturates at MAX_LS_STREAK.
  - Clears on any if grant.
  - Clears on an ls grant made while if_req_valid is 0.
- Fetch requests drive mem_wen = 0 and mem_wdata = 0.
- REQ:
  - mem_req_valid = 1, with mem_addr, mem_wdata and mem_wen driven from the registers and held stable until mem_req_ready.
  - On a cycle where mem_req_valid && mem_req_ready, go to RESP.
- RESP:
  - mem_req_valid = 0. Wait for mem_resp_valid.
  - On mem_resp_valid, register the response data, and next cycle pulse the owner's resp_valid for exactly one cycle.
  - The FSM is back in IDLE in that pulse cycle, so a new request may be accepted in the same cycle as the previous response pulse.
- mem_resp_valid is ignored outside RESP. The memory guarantees at least one cycle between request handshake and response.
- Response data:
  - Fetch: if_resp_rdata = mem_rdata[31:0] when the latched addr[2] = 0, mem_rdata[63:32] when it = 1.
  - Load: ls_resp_rdata = mem_rdata.
  - Store: ls_resp_rdata = 0.
  - Response data holds its value between pulses.
- Timing with zero-wait memory (mem_req_ready = 1, response one cycle after handshake): accept cycle 0, handshake cycle 1, mem_resp_valid cycle 2, resp_valid cycle 3. Back-to-back issue interval is 3 cycles.
- Requester valids may drop without acceptance; nothing is latched unless ready was asserted.

Test Plan:
- Single fetch: if addr 0x1004; memory returns 0xDEADBEEF_12345678 in cycle 2 -> mem_addr 0x1000 in cycle 1, if_resp_valid cycle 3 with rdata 0xDEADBEEF. Same test with addr 0x1000 -> 0x12345678.
- Simultaneous requests: both valid in cycle 0 -> ls_req_ready = 1 and if_req_ready = 0 in cycle 0; if accepted in cycle 3; responses in order ls then if.
- Starvation, MAX_LS_STREAK = 2: both valids held high for 6 grants -> grant order ls, ls, if, ls, ls, if.
- Store with backpressure: ls wen = 1, addr 0x80, wdata 0xA5A5; mem_req_ready low 5 cycles -> mem_req_valid, mem_addr 0x80, mem_wdata 0xA5A5 and mem_wen = 1 held stable throughout; ls_resp_valid pulses once with rdata 0.
- Reset in RESP: assert rst one cycle before mem_resp_valid -> no resp_valid pulses, all outputs 0, FSM IDLE; a new fetch after reset completes normally.
- Stray response: mem_resp_valid pulsed in IDLE -> no resp_valid, no state change.
